rc_servo_multi_pwm: RTL and testbench
=====================================

RC_SERVO_MULTI_PWM -- requirements
Module: rc_servo_multi_pwm

Interface
REQ-001 SHALL provide parameter NUM_CH, default 8, the number of independent servo channels (1..32).
REQ-002 SHALL provide parameter CNT_W, default 20, the width of the period counter, on-timers and pulse-width values.
REQ-003 SHALL provide parameter PERIOD, default 1000000, the servo frame length in clk cycles (20 ms at 50 MHz).
REQ-004 SHALL provide parameter PW_MIN, default 25000, the minimum pulse width in clk cycles (0.5 ms).
REQ-005 SHALL provide parameter PW_MAX, default 125000, the maximum pulse width in clk cycles (2.5 ms).
REQ-006 SHALL have clk, input, 1 bit: the clock, with all state updated on its rising edge.
REQ-007 SHALL have reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have wr_en, input, 1 bit: a one-cycle strobe that writes the shadow pulse width.
REQ-009 SHALL have wr_ch, input, $clog2(NUM_CH) bits (minimum 1): the target channel index.
REQ-010 SHALL have wr_pw, input, CNT_W bits: the requested pulse width in clk cycles.
REQ-011 SHALL have ch_enable, input, NUM_CH bits: per-channel enable, 1 = run.
REQ-012 SHALL have servo_out, output, NUM_CH bits: the per-channel pulse outputs.
REQ-013 SHALL have period_start, output, 1 bit: high for one cycle when the period counter equals 0.
REQ-014 SHALL have ch_active, output, NUM_CH bits: 1 when the channel FSM is in any state other than S_IDLE.

Function
REQ-015 The period counter SHALL count 0..PERIOD-1 and wrap to 0, free-running from reset release, with period_start = (count == 0).
REQ-016 An elaboration-time check SHALL fail unless PW_MIN >= 1, PW_MIN <= PW_MAX, PW_MAX <= PERIOD-4 and PERIOD < 2^CNT_W.
REQ-017 A write with wr_en=1 and wr_ch < NUM_CH SHALL update that channel's shadow register on the next edge with wr_pw clamped to [PW_MIN, PW_MAX].
REQ-018 A write with wr_ch >= NUM_CH SHALL be ignored and SHALL change no state.
REQ-019 Each channel SHALL contain an independent Moore FSM with states S_IDLE, S_WAIT, S_LOAD, S_ON and S_OFF.
REQ-020 The FSM transitions SHALL be:
- S_IDLE -> S_WAIT when ch_enable[i]=1.
- S_WAIT -> S_IDLE when ch_enable[i]=0; else S_WAIT -> S_LOAD when period_start=1.
- S_LOAD -> S_ON unconditionally.
- S_ON -> S_OFF when on_timer == 1.
- S_OFF -> S_WAIT if ch_enable[i]=1, else S_IDLE.
REQ-021 In S_LOAD the FSM SHALL copy shadow to active and load on_timer with the same value.
REQ-022 on_timer SHALL decrement by 1 on each cycle spent in S_ON.
REQ-023 servo_out[i] SHALL be 1 only in S_ON, giving a high time of exactly active_pw cycles.
REQ-024 servo_out[i] SHALL rise exactly 2 clk cycles after the cycle in which period_start=1.
REQ-025 Deasserting ch_enable[i] during S_LOAD or S_ON SHALL NOT truncate the pulse; the pulse completes and the FSM then enters S_IDLE.
REQ-026 A write in any cycle, including the S_LOAD cycle of the same channel, SHALL NOT alter the pulse in progress.
REQ-027 A write landing in the S_LOAD cycle SHALL be loaded by S_LOAD using the pre-write shadow, with the new value taking effect in the following period.
REQ-028 Multiple writes within one period SHALL leave only the last value effective.
REQ-029 Channels SHALL be mutually independent; all enabled channels SHALL start their pulses in the same cycle.
REQ-030 Outputs SHALL be driven from registered state or state decode only, with no combinational path from inputs to outputs.

Reset
REQ-031 While reset=0 the block SHALL hold:
- period counter = 0, every FSM in S_IDLE, on_timer = 0;
- shadow and active = (PW_MIN+PW_MAX)/2;
- servo_out = 0, ch_active = 0, period_start = 0.
REQ-032 Reset asserted mid-pulse SHALL drive servo_out low immediately (asynchronously).
REQ-033 After reset release, period_start SHALL first assert in the first cycle after release.

Verification (NUM_CH=4, CNT_W=12, PERIOD=1000, PW_MIN=50, PW_MAX=200)
REQ-034 Bench SHALL check default pulse: enable ch0 only -> servo_out[0] high for 125 cycles starting 2 cycles after each period_start, other channels stay low.
REQ-035 Bench SHALL check clamping: writes of 10 to ch1 and 4000 to ch2 -> next period pulses of 50 and 200 cycles.
REQ-036 Bench SHALL check the update boundary: write 80 to ch0 mid-pulse -> current pulse stays 125, next pulse is 80.
REQ-037 Bench SHALL check the S_LOAD collision: write 150 to ch3 in its S_LOAD cycle -> pulse uses the old value, 150 appears in the following period.
REQ-038 Bench SHALL check disable mid-pulse: drop ch_enable[0] at cycle 30 of the pulse -> full-width pulse, then ch_active[0]=0 and no further pulses; a write to wr_ch=5 is ignored.
REQ-039 Bench SHALL check reset mid-pulse: assert reset during S_ON -> servo_out=0 at once; after release the defaults of REQ-031 hold and operation resumes per REQ-034.

Source files
------------

// File: rtl/rc_servo_multi_pwm.sv
// Multi-channel RC servo pulse generator: one shared frame counter and one
// small Moore FSM per channel that emits a pulse of the latched width each frame.
module rc_servo_multi_pwm #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 20,
  parameter int PERIOD = 1000000,
  parameter int PW_MIN = 25000,
  parameter int PW_MAX = 125000
) (
  input  logic                                         clk,
  input  logic                                         reset,
  // wr_en is a fire-and-forget strobe: no ready/back-pressure, every cycle
  // with wr_en=1 is one accepted write; out-of-range channels are dropped.
  input  logic                                         wr_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic [CNT_W-1:0]                             wr_pw,
  input  logic [NUM_CH-1:0]                            ch_enable,
  output logic [NUM_CH-1:0]                            servo_out,
  output logic                                         period_start,
  output logic [NUM_CH-1:0]                            ch_active,
  output logic [3*NUM_CH-1:0]                          dbg_state,
  output logic [CNT_W*NUM_CH-1:0]                      dbg_active_pw
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] PW_LO  = CNT_W'(PW_MIN);
  localparam logic [CNT_W-1:0] PW_HI  = CNT_W'(PW_MAX);
  localparam logic [CNT_W-1:0] PW_MID = CNT_W'((PW_MIN + PW_MAX) / 2);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);

  generate
    if (NUM_CH < 1 || NUM_CH > 32 || PW_MIN < 1 || PW_MIN > PW_MAX ||
        PW_MAX > PERIOD - 4 || longint'(PERIOD) >= (64'd1 << CNT_W)) begin : g_param_check
      $error("rc_servo_multi_pwm: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_LOAD = 3'd2,
    S_ON   = 3'd3,
    S_OFF  = 3'd4
  } state_t;

  logic [CNT_W-1:0] r_count;
  logic             r_run;
  logic [CNT_W-1:0] w_wr_pw;

  // r_run holds the counter at 0 for one cycle after release so that the
  // first frame starts in the first cycle after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign period_start = r_run && (r_count == '0);

  always_comb begin
    w_wr_pw = wr_pw;
    if (wr_pw < PW_LO)      w_wr_pw = PW_LO;
    else if (wr_pw > PW_HI) w_wr_pw = PW_HI;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_timer;
    logic             w_wr_hit;

    assign w_wr_hit = wr_en && (wr_ch == CH_W'(i));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
    end

    always_comb begin
      w_next = r_state;
      case (r_state)
        S_IDLE:  if (ch_enable[i]) w_next = S_WAIT;
        S_WAIT: begin
          if (!ch_enable[i])     w_next = S_IDLE;
          else if (period_start) w_next = S_LOAD;
        end
        S_LOAD:  w_next = S_ON;
        S_ON:    if (r_timer == CNT_W'(1)) w_next = S_OFF;
        S_OFF:   w_next = ch_enable[i] ? S_WAIT : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end

    // S_LOAD samples the shadow before any same-cycle write lands, so a
    // colliding write only affects the next frame.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_shadow <= PW_MID;
        r_active <= PW_MID;
        r_timer  <= '0;
      end else begin
        if (w_wr_hit) r_shadow <= w_wr_pw;
        if (r_state == S_LOAD) begin
          r_active <= r_shadow;
          r_timer  <= r_shadow;
        end else if (r_state == S_ON) begin
          r_timer <= r_timer - 1'b1;
        end
      end
    end

    assign servo_out[i]                     = (r_state == S_ON);
    assign ch_active[i]                     = (r_state != S_IDLE);
    assign dbg_state[3*i +: 3]              = r_state;
    assign dbg_active_pw[CNT_W*i +: CNT_W]  = r_active;
  end

endmodule

// File: tb/tb_rc_servo_multi_pwm.sv
// Bench for rc_servo_multi_pwm: a pulse monitor pops expected {channel, width}
// entries from a queue; scenario tasks push expectations and check state inline.
module tb_rc_servo_multi_pwm;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 12;
  localparam int PERIOD = 1000;
  localparam int PW_MIN = 50;
  localparam int PW_MAX = 200;
  localparam int PW_DEF = (PW_MIN + PW_MAX) / 2;
  localparam int W      = 16;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // main DUT signals
  logic              wr_en = 1'b0;
  logic [1:0]        wr_ch = '0;
  logic [CNT_W-1:0]  wr_pw = '0;
  logic [NUM_CH-1:0] ch_enable = '0;
  logic [NUM_CH-1:0] servo_out;
  logic              period_start;
  logic [NUM_CH-1:0] ch_active;
  logic [3*NUM_CH-1:0]     dbg_state;
  logic [CNT_W*NUM_CH-1:0] dbg_active_pw;

  // five-channel DUT, so that wr_ch can encode indices past the last channel
  logic             wr_en5 = 1'b0;
  logic [2:0]       wr_ch5 = '0;
  logic [CNT_W-1:0] wr_pw5 = '0;
  logic [4:0]       ch_enable5 = '0;
  logic [4:0]       servo_out5;
  logic             period_start5;
  logic [4:0]       ch_active5;
  logic [14:0]      dbg_state5;
  logic [CNT_W*5-1:0] dbg_active_pw5;

  rc_servo_multi_pwm #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX)
  ) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pw(wr_pw),
    .ch_enable(ch_enable), .servo_out(servo_out), .period_start(period_start),
    .ch_active(ch_active), .dbg_state(dbg_state), .dbg_active_pw(dbg_active_pw)
  );

  rc_servo_multi_pwm #(
    .NUM_CH(5), .CNT_W(CNT_W), .PERIOD(PERIOD), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX)
  ) u_dut5 (
    .clk(clk), .reset(reset), .wr_en(wr_en5), .wr_ch(wr_ch5), .wr_pw(wr_pw5),
    .ch_enable(ch_enable5), .servo_out(servo_out5), .period_start(period_start5),
    .ch_active(ch_active5), .dbg_state(dbg_state5), .dbg_active_pw(dbg_active_pw5)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ps_cyc = 0;
  int rise_cyc [NUM_CH];
  logic [NUM_CH-1:0] prev_out = '0;
  logic [W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp5_q[$];
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;

  function automatic logic [CNT_W-1:0] clamp_pw(input int pw);
    if (pw < PW_MIN) return CNT_W'(PW_MIN);
    if (pw > PW_MAX) return CNT_W'(PW_MAX);
    return CNT_W'(pw);
  endfunction

  function automatic logic [W-1:0] ent(input int ch, input int pw);
    return {4'(ch), 12'(pw)};
  endfunction

  // pulse monitor: samples on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (!reset) begin
        prev_out = '0;
      end else begin
        if (period_start) ps_cyc = cyc;
        for (int i = 0; i < NUM_CH; i++) begin
          if (servo_out[i] && !prev_out[i]) begin
            rise_cyc[i] = cyc;
            total++;
            if (cyc - ps_cyc != 2) begin
              bad++;
              $display("FAIL rise_offset ch%0d: got %0d want 2", i, cyc - ps_cyc);
            end
          end
          if (!servo_out[i] && prev_out[i]) begin
            mon_got = ent(i, cyc - rise_cyc[i]);
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_pulse: got ch%0d width %0d want none", i, cyc - rise_cyc[i]);
            end else begin
              mon_exp = exp_q.pop_front();
              if (mon_got !== mon_exp) begin
                bad++;
                $display("FAIL pulse: got ch%0d width %0d want ch%0d width %0d",
                         mon_got[15:12], mon_got[11:0], mon_exp[15:12], mon_exp[11:0]);
              end
            end
          end
        end
        prev_out = servo_out;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic goto_cycle(input int n);
    for (int k = 0; k < 2100; k++) begin
      if (reset && (cyc - ps_cyc == n)) return;
      tick();
    end
    total++;
    bad++;
    $display("FAIL goto_cycle: got timeout want frame phase %0d", n);
  endtask

  task automatic next_period();
    tick();
    goto_cycle(0);
  endtask

  task automatic write_pw(input int ch, input int pw);
    wr_en = 1'b1;
    wr_ch = 2'(ch);
    wr_pw = CNT_W'(pw);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic write_pw5(input int ch, input int pw);
    wr_en5 = 1'b1;
    wr_ch5 = 3'(ch);
    wr_pw5 = CNT_W'(pw);
    tick();
    wr_en5 = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    ch_enable = '0;
    repeat (3) tick();
    total++; if (servo_out !== 4'b0000) begin bad++; $display("FAIL reset_servo_out: got %b want 0000", servo_out); end
    total++; if (ch_active !== 4'b0000) begin bad++; $display("FAIL reset_ch_active: got %b want 0000", ch_active); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL reset_period_start: got %b want 0", period_start); end
    total++; if (dbg_state !== '0) begin bad++; $display("FAIL reset_state: got %h want 0", dbg_state); end
    total++; if (dbg_active_pw !== {NUM_CH{12'(PW_DEF)}}) begin bad++; $display("FAIL reset_active_pw: got %h want %0d each", dbg_active_pw, PW_DEF); end
    ch_enable = 4'b0001;
    reset = 1'b1;
    tick();
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL first_period_start: got %b want 1", period_start); end
    total++; if (ch_active !== 4'b0001) begin bad++; $display("FAIL first_ch_active: got %b want 0001", ch_active); end
  endtask

  task automatic test_default_pulse();
    exp_q.push_back(ent(0, PW_DEF));
    next_period();
    exp_q.push_back(ent(0, PW_DEF));
    goto_cycle(1);
    total++; if (servo_out !== 4'b0000) begin bad++; $display("FAIL load_cycle_low: got %b want 0000", servo_out); end
    total++; if (dbg_state[2:0] !== 3'd2) begin bad++; $display("FAIL load_state: got %0d want 2", dbg_state[2:0]); end
    goto_cycle(2);
    total++; if (servo_out !== 4'b0001) begin bad++; $display("FAIL default_rise: got %b want 0001", servo_out); end
    goto_cycle(PW_DEF + 1);
    total++; if (servo_out !== 4'b0001) begin bad++; $display("FAIL default_last_high: got %b want 0001", servo_out); end
    goto_cycle(PW_DEF + 2);
    total++; if (servo_out !== 4'b0000) begin bad++; $display("FAIL default_fall: got %b want 0000", servo_out); end
  endtask

  task automatic test_clamp();
    goto_cycle(200);
    write_pw(1, 10);
    write_pw(2, 4000);
    ch_enable = 4'b0111;
    exp_q.push_back(ent(1, clamp_pw(10)));
    exp_q.push_back(ent(0, PW_DEF));
    exp_q.push_back(ent(2, clamp_pw(4000)));
    next_period();
    total++; if (ch_active !== 4'b0111) begin bad++; $display("FAIL clamp_ch_active: got %b want 0111", ch_active); end
  endtask

  task automatic test_update_boundary();
    goto_cycle(60);
    write_pw(0, 80);
    exp_q.push_back(ent(1, clamp_pw(10)));
    exp_q.push_back(ent(0, 80));
    exp_q.push_back(ent(2, clamp_pw(4000)));
    next_period();
  endtask

  task automatic test_sload_collision();
    goto_cycle(250);
    ch_enable = 4'b1001;
    exp_q.push_back(ent(0, 80));
    exp_q.push_back(ent(3, PW_DEF));
    next_period();
    goto_cycle(1);
    total++; if (dbg_state[11:9] !== 3'd2) begin bad++; $display("FAIL ch3_in_load: got %0d want 2", dbg_state[11:9]); end
    write_pw(3, 150);
    exp_q.push_back(ent(0, 80));
    exp_q.push_back(ent(3, 150));
    total++; if (dbg_active_pw[47:36] !== 12'(PW_DEF)) begin bad++; $display("FAIL ch3_active_pre_write: got %0d want %0d", dbg_active_pw[47:36], PW_DEF); end
  endtask

  task automatic test_disable_mid_pulse();
    next_period();
    goto_cycle(32);
    total++; if (servo_out !== 4'b1001) begin bad++; $display("FAIL disable_pre: got %b want 1001", servo_out); end
    ch_enable = 4'b0000;
    goto_cycle(160);
    total++; if (ch_active !== 4'b0000) begin bad++; $display("FAIL disable_ch_active: got %b want 0000", ch_active); end
    total++; if (dbg_state !== '0) begin bad++; $display("FAIL disable_state: got %h want 0", dbg_state); end
  endtask

  task automatic test_ignore_bad_channel();
    int cnt [5];
    ch_enable5 = 5'b11111;
    write_pw5(5, 80);
    write_pw5(7, 4000);
    write_pw5(6, 10);
    for (int i = 0; i < 5; i++) exp5_q.push_back(12'(PW_DEF));
    next_period();
    total++; if (period_start5 !== 1'b1) begin bad++; $display("FAIL dut5_period_start: got %b want 1", period_start5); end
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    repeat (300) begin
      tick();
      for (int i = 0; i < 5; i++) cnt[i] += int'(servo_out5[i]);
    end
    for (int i = 0; i < 5; i++) begin
      logic [CNT_W-1:0] e;
      e = exp5_q.pop_front();
      total++;
      if (cnt[i] != int'(e)) begin bad++; $display("FAIL ignore_write ch%0d: got width %0d want %0d", i, cnt[i], e); end
    end
    ch_enable5 = 5'b00000;
  endtask

  task automatic test_reset_mid_pulse();
    ch_enable = 4'b0001;
    next_period();
    goto_cycle(50);
    total++; if (servo_out !== 4'b0001) begin bad++; $display("FAIL pre_reset_high: got %b want 0001", servo_out); end
    reset = 1'b0;
    #1;
    total++; if (servo_out !== 4'b0000) begin bad++; $display("FAIL async_reset_out: got %b want 0000", servo_out); end
    total++; if (ch_active !== 4'b0000) begin bad++; $display("FAIL async_reset_active: got %b want 0000", ch_active); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL async_reset_ps: got %b want 0", period_start); end
    repeat (3) tick();
    total++; if (dbg_state !== '0) begin bad++; $display("FAIL held_reset_state: got %h want 0", dbg_state); end
    total++; if (dbg_active_pw !== {NUM_CH{12'(PW_DEF)}}) begin bad++; $display("FAIL held_reset_active_pw: got %h want %0d each", dbg_active_pw, PW_DEF); end
    reset = 1'b1;
    tick();
    total++; if (period_start !== 1'b1) begin bad++; $display("FAIL restart_period_start: got %b want 1", period_start); end
    exp_q.push_back(ent(0, PW_DEF));
    goto_cycle(200);
    ch_enable = 4'b0000;
    goto_cycle(300);
  endtask

  initial begin
    test_reset();
    test_default_pulse();
    test_clamp();
    test_update_boundary();
    test_sload_collision();
    test_disable_mid_pulse();
    test_ignore_bad_channel();
    test_reset_mid_pulse();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expected: got %0d pending want 0", exp_q.size()); end
    total++;
    if (exp5_q.size() != 0) begin bad++; $display("FAIL leftover_expected5: got %0d pending want 0", exp5_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
